// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one combinational ALU between requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [3:0]  req_ctr0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [3:0]  req_ctr1,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_out,
    output logic        resp_less,
    output logic        resp_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    input  logic [31:0] alu_out,
    input  logic        alu_less,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_ctr;
    logic        r_owner;
    logic [31:0] r_out;
    logic        r_less;
    logic        r_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        r_last;
`endif

    logic        w_grant;
    logic        w_sel;

    // w_sel is the winning port index when a grant happens
    always_comb begin
        w_grant = (r_state == IDLE) && (|req_valid) && !rst;
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_sel   = (req_valid == 2'b10);
`else
        w_sel   = req_valid[1] && (!req_valid[0] || !r_last);
`endif
    end

    always_comb begin
        req_ready = 2'b00;
        if (w_grant)
            req_ready = w_sel ? 2'b10 : 2'b01;
    end

    always_comb begin
        resp_valid = 2'b00;
        if (r_state == RESP)
            resp_valid = r_owner ? 2'b10 : 2'b01;
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_ctr   = r_ctr;
    assign resp_out  = r_out;
    assign resp_less = r_less;
    assign resp_zero = r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_ctr   <= '0;
            r_owner <= 1'b0;
            r_out   <= '0;
            r_less  <= 1'b0;
            r_zero  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last  <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_a     <= w_sel ? req_a1 : req_a0;
                        r_b     <= w_sel ? req_b1 : req_b0;
                        r_ctr   <= w_sel ? req_ctr1 : req_ctr0;
                        r_owner <= w_sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last  <= w_sel;
`endif
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_out   <= alu_out;
                    r_less  <= alu_less;
                    r_zero  <= alu_zero;
                    r_state <= RESP;
                end
                RESP: begin
                    // only the owner's resp_ready completes the handshake
                    if (resp_ready[r_owner])
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one ALU instance between two requesters, e.g. the EXU and a multi-cycle address/branch helper. It accepts an operation `{a, b, ctr}` from one requester at a time using valid/ready handshakes. It drives the shared ALU from registered operands, captures `out`/`less`/`zero`, and returns the result to the owning requester through a response handshake. The ALU itself stays a separate, purely combinational instance wired to the `alu_*` ports.

## Interface
- No parameters; data width fixed at 32, ALU control at 4 bits (same encoding as the ALU `ctr` input).
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  2  per-port request valid (bit i = port i)
- `req_ready`  out  2  per-port request accept; at most one bit high
- `req_a0`, `req_b0`  in  32 each  port 0 operands
- `req_ctr0`  in  4  port 0 ALU control
- `req_a1`, `req_b1`  in  32 each  port 1 operands
- `req_ctr1`  in  4  port 1 ALU control
- `resp_valid`  out  2  per-port response valid; at most one bit high
- `resp_ready`  in  2  per-port response accept
- `resp_out`  out  32  result, shared by both ports; meaningful only where `resp_valid` is set
- `resp_less`  out  1  captured ALU `less`
- `resp_zero`  out  1  captured ALU `zero`
- `alu_a`, `alu_b`  out  32 each  to shared ALU
- `alu_ctr`  out  4  to shared ALU
- `alu_out`  in  32  from shared ALU
- `alu_less`, `alu_zero`  in  1 each  from shared ALU

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, choose a winner and assert that port's `req_ready` combinationally in the same cycle.
  - Latch the winner's a/b/ctr into operand registers and the port index into `owner`; go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE with `req_ready`=0.
- Arbitration (default, round-robin):
  - A lone requester always wins.
  - When both are valid, the port not granted last wins.
  - Priority pointer `last` resets to 1, so port 0 wins the first tie.
  - `last` updates only on grant.
- EXEC:
  - `alu_*` are driven from the operand registers. This is true in all states; reset value 0.
  - Capture `alu_out`/`alu_less`/`alu_zero` into result registers; go to RESP.
- RESP:
  - `resp_valid[owner]`=1.
  - Result registers are held stable while `resp_valid[owner]`=1.
  - On `resp_ready[owner]`=1, go to IDLE in the next cycle.
  - `resp_ready` of the non-owner port is ignored.
- `req_ready` is 0 outside IDLE. A request arriving in EXEC/RESP waits; requesters hold valid and payload stable until accepted.
- The arbiter never reorders or drops an accepted operation except on reset.
- Reset outputs: `req_ready`=0, `resp_valid`=0, `resp_out`=0, `resp_less`=0, `resp_zero`=0, `alu_a`=0, `alu_b`=0, `alu_ctr`=0.
- Reset in EXEC or RESP aborts the in-flight operation silently: no response is issued, and state returns to IDLE on the next cycle.

## Timing
- Request accepted at edge T (IDLE, valid & ready): EXEC in cycle T+1, `resp_valid` high in cycle T+2.
- `resp_ready` already high in T+2: handshake completes at T+2, IDLE at T+3, next accept possible at T+3.
- Minimum issue interval is 3 cycles per operation.
- Each extra cycle of `resp_ready`=0 adds one cycle.
- Arbitration starvation bound: with both ports continuously valid, each port is granted every second operation.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, port 0 always wins a tie; `last` is unused and may be removed.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single request: port 0 valid, a=5, b=7, ctr=4'b1000 (sub) at T.
  - `req_ready`=2'b01 at T.
  - `resp_valid`=2'b01 at T+2 with `resp_out`=0xFFFFFFFE, less=1, zero=0.
- Tie, round-robin: both ports continuously valid, port 0 doing add 1+2, port 1 doing sll 1<<31 (ctr=4'b0001).
  - Grants alternate 0, 1, 0, 1.
  - Responses 0x00000003 (port 0) and 0x80000000 (port 1).
- Backpressure: port 1 request; hold `resp_ready`=0 for 4 cycles.
  - `resp_valid`=2'b10 and the result stay stable.
  - A concurrent port 0 request sees `req_ready`=0 until one cycle after the response handshake.
- Reset mid-operation: assert `rst` in EXEC.
  - Next cycle all outputs are 0 and no response is issued.
  - A fresh request afterwards completes normally at T+2.
- Fixed priority, built with `ALU_ARB_FIXED_PRIO_EN`: both ports continuously valid, port 0 doing a=b=9 with ctr=4'b1000.
  - Port 0 wins every grant and port 1 is never granted.
  - Each port 0 response has `resp_zero`=1 and `resp_out`=0.
